fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of Decode. Holds the program counter (PCF), issues single-outstanding requests to instruction memory, absorbs back-pressure from the hazard unit in a one-entry hold buffer, applies Decode-resolved branch redirects (PCSrcD/PCBranchD), and drives the IF/ID pipeline register that feeds InstrD/PCPlus4D into Decode.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HELD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response handshake between fetch (master) and imem (slave).
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: bubble beats load; neither means hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pcPlus4,
  output logic [31:0] o_instrD,
  output logic [31:0] o_pcD,
  output logic [31:0] o_pcPlus4D,
  output logic        o_validD
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pcPlus4;
  logic        r_valid;

  // A bubble only replaces the instruction; PCD/PCPlus4D keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
      r_pc      <= 32'h0;
      r_pcPlus4 <= 32'h0;
    end else if (i_bubble) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_pcPlus4 <= i_pcPlus4;
      r_valid   <= 1'b1;
    end
  end

  assign o_instrD   = r_instr;
  assign o_pcD      = r_pc;
  assign o_pcPlus4D = r_pcPlus4;
  assign o_validD   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PCF, single-outstanding imem requests, one-entry hold buffer, redirects.
// Defining FETCH_PERF_CNT_EN adds o_fetch_cnt / o_bubble_cnt performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_StallF,
  input  logic        i_StallD,
  input  logic        i_FlushD,
  input  logic        i_PCSrcD,
  input  logic [31:0] i_PCBranchD,
  fetch_if.master     imem,
  output logic [31:0] o_InstrD,
  output logic [31:0] o_PCD,
  output logic [31:0] o_PCPlus4D,
  output logic        o_ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pcF;
  logic [31:0]  r_holdBuf;
  logic         r_squash;

  logic         w_redirect;
  logic         w_accept;
  logic         w_req;
  logic         w_respValid;
  logic         w_newAvail;
  logic         w_load;
  logic         w_bubble;
  logic [31:0]  w_pcPlus4;
  logic [31:0]  w_newInstr;

  assign w_redirect  = i_PCSrcD & ~i_StallD;
  assign w_accept    = ~i_StallD & ~i_FlushD & ~w_redirect;
  assign w_pcPlus4   = r_pcF + 32'd4;
  assign w_req       = ~rst & (r_state == IDLE) & ~i_StallF & ~w_redirect;
  // A squashed response belongs to a pre-redirect PC and never reaches IF/ID.
  assign w_respValid = (r_state == WAIT) & imem.imem_valid & ~r_squash;
  assign w_newAvail  = w_respValid | (r_state == HELD);
  assign w_newInstr  = (r_state == HELD) ? r_holdBuf : imem.imem_rdata;
  assign w_load      = w_accept & w_newAvail;
  assign w_bubble    = i_FlushD | w_redirect | (~i_StallD & ~w_newAvail);

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pcF;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pcF     <= RESET_PC;
      r_squash  <= 1'b0;
      r_holdBuf <= 32'h0;
    end else begin
      if (w_redirect) begin
        r_pcF <= i_PCBranchD;
      end else if (w_load) begin
        r_pcF <= w_pcPlus4;
      end
      case (r_state)
        IDLE: begin
          if (w_req) r_state <= WAIT;
        end
        WAIT: begin
          if (imem.imem_valid) begin
            r_squash <= 1'b0;
            if (w_respValid && i_StallD && !i_FlushD) begin
              r_holdBuf <= imem.imem_rdata;
              r_state   <= HELD;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_redirect) begin
            // Keep waiting so the in-flight response drains before refetching.
            r_squash <= 1'b1;
          end
        end
        HELD: begin
          if (w_accept || i_FlushD || w_redirect) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_bubble   (w_bubble),
    .i_instr    (w_newInstr),
    .i_pc       (r_pcF),
    .i_pcPlus4  (w_pcPlus4),
    .o_instrD   (o_InstrD),
    .o_pcD      (o_PCD),
    .o_pcPlus4D (o_PCPlus4D),
    .o_validD   (o_ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetchCnt;
  logic [31:0] r_bubbleCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchCnt  <= 32'h0;
      r_bubbleCnt <= 32'h0;
    end else begin
      if (w_load)   r_fetchCnt  <= r_fetchCnt + 32'd1;
      if (w_bubble) r_bubbleCnt <= r_bubbleCnt + 32'd1;
    end
  end

  assign o_fetch_cnt  = r_fetchCnt;
  assign o_bubble_cnt = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: IDLE request table plus scoreboarded fetch sequences.
module tb_fetch_stage;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pcSrc;
    logic [31:0] branch;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, flushD, pcSrc;
  logic [31:0] pcBranch;
  logic [31:0] instrD, pcD, pcPlus4D;
  logic        validD;
  logic [31:0] instrW, pcW, pcPlus4W;
  logic        validW;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt, bubbleCnt, fetchCntW, bubbleCntW;
`endif

  fetch_if memIf ();
  fetch_if memW ();

  int          checks = 0;
  int          errors = 0;
  exp_t        sbQ[$];
  vec_t        vecs[7];
  int          memLatency = 1;
  int          memCount = 0;
  logic        memPending = 1'b0;
  logic [31:0] memAddr = 32'h0;
  logic        pendW = 1'b0;
  logic [31:0] addrW = 32'h0;
  logic        lastReq, lastReqW;
  logic [31:0] lastAddr, lastAddrW;
  logic        prevValid = 1'b0;
  logic [31:0] prevPC = 32'h0;
  logic [31:0] prevInstr = 32'h0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .i_StallF    (stallF),
    .i_StallD    (stallD),
    .i_FlushD    (flushD),
    .i_PCSrcD    (pcSrc),
    .i_PCBranchD (pcBranch),
    .imem        (memIf),
    .o_InstrD    (instrD),
    .o_PCD       (pcD),
    .o_PCPlus4D  (pcPlus4D),
    .o_ValidD    (validD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt  (fetchCnt),
    .o_bubble_cnt (bubbleCnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk         (clk),
    .rst         (rst),
    .i_StallF    (stallF),
    .i_StallD    (stallD),
    .i_FlushD    (flushD),
    .i_PCSrcD    (pcSrc),
    .i_PCBranchD (pcBranch),
    .imem        (memW),
    .o_InstrD    (instrW),
    .o_PCD       (pcW),
    .o_PCPlus4D  (pcPlus4W),
    .o_ValidD    (validW)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt  (fetchCntW),
    .o_bubble_cnt (bubbleCntW)
`endif
  );

  // Distinct addi x1,x0,imm word per address so every fetch is identifiable.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[11:0], 20'h00093};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                               input logic pS, input logic [31:0] br);
    stallF   = sF;
    stallD   = sD;
    flushD   = fD;
    pcSrc    = pS;
    pcBranch = br;
  endtask

  task automatic expectLoad(input logic [31:0] a);
    sbQ.push_back('{memWord(a), a, a + 32'd4});
  endtask

  // Every fresh ValidD=1 content in IF/ID must match the oldest queued expectation.
  task automatic monitorIfId();
    exp_t e;
    if (validD === 1'b1 && (!prevValid || pcD !== prevPC || instrD !== prevInstr)) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected load: got pc %h instr %h, expected none", pcD, instrD);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb InstrD", instrD, e.instr);
        checkOutput("sb PCD", pcD, e.pc);
        checkOutput("sb PCPlus4D", pcPlus4D, e.pc4);
      end
    end
    prevValid = (validD === 1'b1);
    prevPC    = pcD;
    prevInstr = instrD;
  endtask

  // One clock period: memory models respond, requests are sampled, then IF/ID is monitored.
  task automatic stepCycle();
    memIf.imem_valid = 1'b0;
    memW.imem_valid  = 1'b0;
    if (rst) begin
      memPending = 1'b0;
      pendW      = 1'b0;
    end else begin
      if (memPending) begin
        memCount--;
        if (memCount == 0) begin
          memIf.imem_valid = 1'b1;
          memIf.imem_rdata = memWord(memAddr);
          memPending       = 1'b0;
        end
      end
      if (pendW) begin
        memW.imem_valid = 1'b1;
        memW.imem_rdata = memWord(addrW);
        pendW           = 1'b0;
      end
    end
    #1;
    lastReq   = memIf.imem_req;
    lastAddr  = memIf.imem_addr;
    lastReqW  = memW.imem_req;
    lastAddrW = memW.imem_addr;
    if (lastReq === 1'b1) begin
      memPending = 1'b1;
      memAddr    = lastAddr;
      memCount   = memLatency;
    end
    if (lastReqW === 1'b1) begin
      pendW = 1'b1;
      addrW = lastAddrW;
    end
    @(posedge clk);
    @(negedge clk);
    monitorIfId();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h80,  1'b0, 32'h80};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h80,  1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200};

    memIf.imem_valid = 1'b0;
    memIf.imem_rdata = 32'h0;
    memW.imem_valid  = 1'b0;
    memW.imem_rdata  = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("req during rst", 32'(lastReq), 32'd0);
    checkOutput("reset InstrD", instrD, NOP_INSTR);
    checkOutput("reset ValidD", 32'(validD), 32'd0);

    // IDLE request gating, one fresh reset per row.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      applyStimulus(vecs[i].stallF, vecs[i].stallD, vecs[i].flushD, vecs[i].pcSrc, vecs[i].branch);
      stepCycle();
      checkOutput($sformatf("vec%0d req", i), 32'(lastReq), 32'(vecs[i].expReq));
      if (vecs[i].expReq) begin
        checkOutput($sformatf("vec%0d addr", i), lastAddr, vecs[i].expAddr);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        checkOutput($sformatf("vec%0d next req", i), 32'(lastReq), 32'd1);
        checkOutput($sformatf("vec%0d next addr", i), lastAddr, vecs[i].expAddr);
      end
    end

    // Basic latency-1 fetch stream.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("first req", 32'(lastReq), 32'd1);
    checkOutput("first addr", lastAddr, 32'h0);
    expectLoad(32'h0);
    stepCycle();
    checkOutput("no req in WAIT", 32'(lastReq), 32'd0);
    checkOutput("ValidD after load", 32'(validD), 32'd1);
    expectLoad(32'h4);
    stepCycle();
    checkOutput("addr 0x4", lastAddr, 32'h4);
    stepCycle();
    stepCycle();
    checkOutput("addr 0x8", lastAddr, 32'h8);

    // StallD across the 0x8 response: hold buffer, then release.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput($sformatf("held req %0d", k), 32'(lastReq), 32'd0);
    end
    checkOutput("held PCD", pcD, 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectLoad(32'h8);
    stepCycle();
    memLatency = 3;
    stepCycle();
    checkOutput("addr 0xC", lastAddr, 32'hC);

    // Redirect while the 0xC request is outstanding (latency 3).
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    stepCycle();
    checkOutput("redirect ValidD", 32'(validD), 32'd0);
    checkOutput("redirect InstrD", instrD, NOP_INSTR);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("squash no req", 32'(lastReq), 32'd0);
    memLatency = 1;
    stepCycle();
    checkOutput("redirect target addr", lastAddr, 32'h100);
    expectLoad(32'h100);
    stepCycle();

    // PCSrcD ignored under StallD.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    stepCycle();
    checkOutput("stalled redirect addr", lastAddr, 32'h104);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectLoad(32'h104);
    stepCycle();

    // Redirect in IDLE to 0x10, then FlushD on its response forces a refetch.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    stepCycle();
    checkOutput("IDLE redirect req", 32'(lastReq), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("addr 0x10", lastAddr, 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("flush InstrD", instrD, NOP_INSTR);
    checkOutput("flush ValidD", 32'(validD), 32'd0);
    checkOutput("flush PCD kept", pcD, 32'h104);
    checkOutput("flush PCPlus4D kept", pcPlus4D, 32'h108);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("refetch addr", lastAddr, 32'h10);
    expectLoad(32'h10);
    stepCycle();

    // Response and redirect in the same cycle: dropped, no squash left behind.
    stepCycle();
    checkOutput("addr 0x14", lastAddr, 32'h14);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    stepCycle();
    checkOutput("same-cycle ValidD", 32'(validD), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("addr 0x40", lastAddr, 32'h40);
    expectLoad(32'h40);
    stepCycle();
    checkOutput("sb drained mid", 32'(sbQ.size()), 32'd0);

    // Reset while a request is outstanding.
    memLatency = 3;
    stepCycle();
    checkOutput("addr 0x44", lastAddr, 32'h44);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    memLatency = 1;
    checkOutput("mid rst InstrD", instrD, NOP_INSTR);
    checkOutput("mid rst PCD", pcD, 32'h0);
    checkOutput("mid rst PCPlus4D", pcPlus4D, 32'h0);

    // Restart from RESET_PC; the wrap instance starts at 0xFFFFFFFC.
    expectLoad(32'h0);
    stepCycle();
    checkOutput("restart addr", lastAddr, 32'h0);
    checkOutput("wrap first addr", lastAddrW, 32'hFFFF_FFFC);
    stepCycle();
    checkOutput("wrap InstrD", instrW, memWord(32'hFFFF_FFFC));
    checkOutput("wrap PCD", pcW, 32'hFFFF_FFFC);
    checkOutput("wrap PCPlus4D", pcPlus4W, 32'h0);
    checkOutput("wrap ValidD", 32'(validW), 32'd1);
    expectLoad(32'h4);
    stepCycle();
    checkOutput("wrap second req", 32'(lastReqW), 32'd1);
    checkOutput("wrap second addr", lastAddrW, 32'h0);
    stepCycle();
    checkOutput("wrap second PCD", pcW, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fetch_cnt", fetchCntW, 32'd2);
    checkOutput("bubble_cnt", bubbleCntW, 32'd2);
`endif
    checkOutput("sb drained end", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
